// File: rtl/disp_mux_pkg.sv
// disp_mux_pkg: frame layout constants, seg7 type and the BCD to 7-segment decode for disp_mux
package disp_mux_pkg;
  localparam int DISP_GRID_LSB = 0;
  localparam int DISP_SEG_DP_OFS = 7;
  typedef logic [6:0] seg7_t;
  function automatic seg7_t bcd_to_seg7(input logic [3:0] bcd);
    case (bcd)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction
endpackage

// File: rtl/disp_seg7_dec.sv
// disp_seg7_dec: combinational BCD to 7-segment decode; non-BCD codes show a dash
module disp_seg7_dec
  import disp_mux_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);
  assign seg = bcd_to_seg7(bcd);
endmodule

// File: rtl/disp_mux.sv
// disp_mux: grid-scanned 7-seg frame word generator with PWM, blanking and a per-scan shadow; DISP_MUX_LZ_BLANK_EN adds leading-zero blanking
module disp_mux
  import disp_mux_pkg::*;
#(
  parameter int NUM_GRID = 8,
  parameter int SEG_LSB  = 32
) (
  input  logic                  rst_n,
  input  logic                  clk,
  input  logic                  tsc_1ppms,
  input  logic [4*NUM_GRID-1:0] digit_bcd,
  input  logic [NUM_GRID-1:0]   dp_mask,
  input  logic [3:0]            brightness,
  input  logic                  blank,
  output logic [255:0]          disp_data,
  output logic                  scan_sof
);
  localparam int GW = $clog2(NUM_GRID);
  logic [GW-1:0] grid_idx;
  logic [3:0] pwm_phase;
  logic [4*NUM_GRID-1:0] shadow_bcd;
  logic [NUM_GRID-1:0] shadow_dp, shadow_lz;
  logic last, seg_on;
  seg7_t seg;
  logic [255:0] word;
  assign last = grid_idx == GW'(NUM_GRID - 1);
`ifdef DISP_MUX_LZ_BLANK_EN
  logic [NUM_GRID-1:0] lz_next;
  logic lead;
  always_comb begin
    lz_next = '0;
    lead = 1'b1;
    for (int i = NUM_GRID - 1; i > 0; i--) begin
      lead = lead & (digit_bcd[4*i +: 4] == 4'd0);
      lz_next[i] = lead;
    end
  end
  // mask travels with the shadow so it always matches the digits on display
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) shadow_lz <= '0;
    else if (tsc_1ppms && last) shadow_lz <= lz_next;
`else
  assign shadow_lz = '0;
`endif
  assign seg_on = !blank && (pwm_phase <= brightness) && !shadow_lz[grid_idx];
  disp_seg7_dec u_dec (.bcd(shadow_bcd[{grid_idx, 2'b00} +: 4]), .seg(seg));
  always_comb begin
    word = '0;
    word[DISP_GRID_LSB + 32'(grid_idx)] = 1'b1;
    word[SEG_LSB +: 7] = seg_on ? seg : 7'd0;
    word[SEG_LSB + DISP_SEG_DP_OFS] = seg_on & shadow_dp[grid_idx];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      disp_data <= '0;
      scan_sof <= 1'b0;
      grid_idx <= '0;
      pwm_phase <= '0;
      shadow_bcd <= '0;
      shadow_dp <= '0;
    end else begin
      scan_sof <= tsc_1ppms && grid_idx == '0;
      if (tsc_1ppms) begin
        disp_data <= word;
        grid_idx <= last ? '0 : GW'(grid_idx + 1'b1);
        pwm_phase <= pwm_phase + 4'd1;
        if (last) begin
          shadow_bcd <= digit_bcd;
          shadow_dp <= dp_mask;
        end
      end
    end
endmodule

// File: tb/tb_disp_mux.sv
// tb_disp_mux: randomized self-checking bench for disp_mux against a slot-count reference model
module tb_disp_mux;
  localparam int NG = 8;
  localparam int SL = 32;
  logic rst_n, clk, tsc;
  logic [4*NG-1:0] digit_bcd;
  logic [NG-1:0] dp_mask;
  logic [3:0] brightness;
  logic blank;
  logic [255:0] disp_data;
  logic scan_sof;
  int n_tests = 0, n_fail = 0;
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  int m_slot;
  logic [3:0] m_sh [NG];
  logic m_dp [NG];
  logic m_lz [NG];
  logic [255:0] last_w;

  disp_mux #(.NUM_GRID(NG), .SEG_LSB(SL)) dut (
    .rst_n(rst_n), .clk(clk), .tsc_1ppms(tsc), .digit_bcd(digit_bcd), .dp_mask(dp_mask),
    .brightness(brightness), .blank(blank), .disp_data(disp_data), .scan_sof(scan_sof)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_slot = 0;
    last_w = '0;
    for (int i = 0; i < NG; i++) begin
      m_sh[i] = 0;
      m_dp[i] = 0;
      m_lz[i] = 0;
    end
  endtask

  // the slot number alone fixes which grid is shown and where the PWM cycle is
  task automatic model_step(output logic [255:0] w, output logic sof);
    int g, ph;
    bit on, lead;
    g = m_slot % NG;
    ph = m_slot % 16;
    on = !blank && ph <= int'(brightness) && !m_lz[g];
    w = '0;
    w[g] = 1'b1;
    if (on) begin
      w[SL +: 7] = seg_tab[m_sh[g]];
      w[SL + 7] = m_dp[g];
    end
    sof = (g == 0);
    if (g == NG - 1) begin
      lead = 1;
      for (int i = NG - 1; i >= 0; i--) begin
        m_sh[i] = digit_bcd[4*i +: 4];
        m_dp[i] = dp_mask[i];
        lead = lead && (m_sh[i] == 0);
`ifdef DISP_MUX_LZ_BLANK_EN
        m_lz[i] = lead && i > 0;
`else
        m_lz[i] = 0;
`endif
      end
    end
    m_slot++;
  endtask

  task automatic slot();
    logic [255:0] w;
    logic sof;
    @(negedge clk);
    tsc = 1;
    model_step(w, sof);
    @(posedge clk);
    #1 tsc = 0;
    last_w = w;
    check("data", disp_data, w);
    check("sof", scan_sof, sof);
    check("onehot", $onehot(disp_data[31:0]), 1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    check("hold", disp_data, last_w);
    check("sof_idle", scan_sof, 0);
  endtask

  task automatic to_grid0_after_capture();
    while (m_slot % NG != NG - 1) slot();
    slot();
    slot();
  endtask

  initial begin
    int cnt;
    rst_n = 0; tsc = 0; digit_bcd = 32'h12345678; dp_mask = 0; brightness = 15; blank = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", disp_data, 0);
    check("rst_sof", scan_sof, 0);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    check("pre_slot", disp_data, 0);
    slot();
    check("first_seg", disp_data[SL +: 7], 7'h3F);
    check("first_grid", disp_data[31:0], 1);
    repeat (8) slot();
    check("scan2_seg", disp_data[SL +: 7], 7'h7F);
    check("scan2_grid", disp_data[31:0], 1);
    repeat (8) begin slot(); idle(); end
    while (m_slot % NG != 4) slot();
    digit_bcd = 32'h87654321;
    repeat (13) slot();
    brightness = 3;
    digit_bcd = 32'h88888888;
    repeat (8) slot();
    cnt = 0;
    repeat (32) begin
      slot();
      if (disp_data[SL +: 7] != 0) cnt++;
    end
    check("pwm_cnt", cnt, 8);
    blank = 1;
    repeat (16) begin slot(); check("blank_seg", disp_data[SL +: 8], 0); end
    blank = 0;
    brightness = 15;
    digit_bcd = 32'h1234567C;
    dp_mask = 8'h01;
    to_grid0_after_capture();
    check("inv_seg", disp_data[SL +: 7], 7'h40);
    check("inv_dp", disp_data[SL + 7], 1);
    dp_mask = 0;
    digit_bcd = 32'h00000105;
    to_grid0_after_capture();
    check("lz_g0", disp_data[SL +: 7], 7'h6D);
    repeat (8) slot();
    digit_bcd = 32'h0;
    to_grid0_after_capture();
    check("zero_g0", disp_data[SL +: 7], 7'h3F);
    repeat (8) slot();
    digit_bcd = 32'h98765432;
    repeat (11) slot();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("midrst_data", disp_data, 0);
    check("midrst_sof", scan_sof, 0);
    model_reset();
    @(negedge clk) rst_n = 1;
    slot();
    check("post_rst_seg", disp_data[SL +: 7], 7'h3F);
    repeat (400) begin
      digit_bcd = $urandom >> (4 * $urandom_range(0, 8));
      dp_mask = 8'($urandom);
      brightness = 4'($urandom_range(0, 15));
      blank = ($urandom_range(0, 7) == 0);
      slot();
      if ($urandom_range(0, 1) == 1) idle();
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk) rst_n = 0;
        #1 model_reset();
        @(negedge clk) rst_n = 1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/disp_mux.md
Name: disp_mux

Overview:
- Upstream feeder for the 256-bit display shift-register stage.
- Time-multiplexes NUM_GRID BCD digits onto a grid-scanned VFD/LED. Each 1 ms slot it presents a 256-bit frame word: one-hot grid enable plus the 7-segment + dp pattern for that grid.
- Applies 16-step brightness PWM and blanking.
- The downstream stage loads disp_data on tsc_1ppms, so the word presented at pulse k was computed at pulse k-1.

Parameters:
- NUM_GRID, 8, number of digits/grids scanned; legal range 2..32.
- SEG_LSB, 32, bit position of segment a within disp_data; legal range 32..248.

Ports:
- rst_n  input  1  async active-low reset
- clk  input  1  system clock
- tsc_1ppms  input  1  1-clk pulse every 1 ms; slot advance
- digit_bcd  input  4*NUM_GRID  BCD digits; digit g in [4g+3:4g]; grid 0 is rightmost
- dp_mask  input  NUM_GRID  decimal point enable per grid
- brightness  input  4  0 = dimmest (1/16 duty), 15 = full on
- blank  input  1  1 = all segments off; grid still scans
- disp_data  output  256  frame word to the shift-register stage
- scan_sof  output  1  1-clk pulse on the edge that emits the grid-0 word

Behaviour:
- Reset is asynchronous, active-low (rst_n); the clock is clk.
- All state updates only on the clk edge where tsc_1ppms=1; otherwise all registers hold.
- Reset values: disp_data=0, scan_sof=0, grid_idx=0, pwm_phase=0, shadow digits=0, shadow dp=0.
- grid_idx counter:
  - Width $clog2(NUM_GRID).
  - Increments per slot; wraps from NUM_GRID-1 to 0.
  - The emitted word uses the grid_idx value before the increment.
- Shadow capture (anti-tear):
  - On a slot edge with grid_idx==NUM_GRID-1, shadow_bcd<=digit_bcd and shadow_dp<=dp_mask.
  - Shadow values are first used by the next emitted word (grid 0).
  - A full scan therefore always shows one coherent snapshot.
- pwm_phase: 4-bit counter, increments every slot, wraps 15 to 0, free-running and independent of grid_idx.
- Segment enable: seg_on = !blank && (pwm_phase <= brightness).
  - brightness=15 means always on; brightness=0 means on in 1 of 16 slots.
  - blank is sampled live, not via the shadow.
- Emitted word on a slot edge, for g = grid_idx:
  - disp_data[g] = 1; all other bits of [31:0] = 0 (the grid stays lit even when seg_on=0).
  - disp_data[SEG_LSB+6:SEG_LSB] = seg_on ? seg7(shadow_bcd[g]) : 0, with bit order a..g in bits 0..6.
  - disp_data[SEG_LSB+7] = seg_on & shadow_dp[g].
  - All other bits = 0.
- seg7 decode: standard 0-9. Codes 10-15 show dash, i.e. segment g only (7'b1000000).
- scan_sof = 1 for exactly the clk cycle after the edge emitting grid 0; otherwise 0.
- Latency: a digit_bcd change reaches disp_data within NUM_GRID+1 slots and becomes visible downstream one slot later.
- Reset mid-scan: all state clears immediately. The first slot after release emits the grid-0 word built from the zeroed shadow (blank digits display "0").
- tsc_1ppms held high for several cycles (illegal): each high cycle counts as a slot; no protection is required.

Optional Feature:
- Macro DISP_MUX_LZ_BLANK_EN enables leading-zero blanking.
- When defined:
  - Scanning from grid NUM_GRID-1 downward, each grid whose shadow digit is 0 and all of whose higher grids are also 0 has its segments and dp forced to 0.
  - Grid 0 is never blanked.
  - The blank mask is computed at shadow capture time and registered with the shadow.
- When undefined: all digits display, including leading zeros; no extra logic.

Decomposition:
- Shared util package gets:
  - constants DISP_GRID_LSB=0 and DISP_SEG_DP_OFS=7;
  - typedef seg7_t (logic [6:0]);
  - a function bcd_to_seg7 returning seg7_t.
- One sub-module, disp_seg7_dec: combinational 4-to-7 decode. It is instantiated once on the muxed digit, not per grid.
- The existing delay module is not needed.

Test Plan:
- Reset value: reset, then 3 slots with digit_bcd=32'h12345678, brightness=15 -> disp_data=0 until the first slot edge. Slot 1 emits grid 0 with the zero shadow: bit 0 set, seg=7'h3F. Shadow captures only at grid 7; grid 0 of the next scan shows '8' (7'h7F) with bit 0 set.
- Full scan at brightness=15: 9 consecutive slots after capture -> grid bits go 0..7 then wrap to 0. Segments follow 8,7,6,5,4,3,2,1 (7'h7F, 7'h07, 7'h7D, ...). scan_sof pulses once per 8 slots.
- Anti-tear: change digit_bcd while grid_idx=3 -> no displayed change until the grid-0 word of the next scan.
- PWM: brightness=3, steady digits over 32 slots -> segments nonzero in exactly 8 slots (phase 0-3 of each 16). Grid bits are always one-hot. blank=1 -> segments 0 in all slots.
- Invalid BCD and dp: digit 0 = 4'hC, dp_mask=8'h01 -> grid-0 word has seg=7'h40 and bit SEG_LSB+7 = 1.
- With DISP_MUX_LZ_BLANK_EN: digit_bcd=32'h00000105 -> grids 7..3 have segments 0. Grid 2 shows '1', grid 1 shows '0', grid 0 shows '5'. digit_bcd=0 -> only grid 0 shows '0'.
